// File: rtl/unidec_engine.sv
// Unique-decodability search engine: walks dangling suffixes
// of a code table under externally supplied choices.
module unidec_engine #(
  parameter int CHAR_BITS  = 3,
  parameter int MAX_LEN    = 5,
  parameter int NUM_WORDS  = 8,
  parameter int STEP_LIMIT = 64,
  localparam int W  = MAX_LEN*CHAR_BITS+1,
  localparam int AW = $clog2(NUM_WORDS),
  localparam int LW = ($clog2(MAX_LEN-1) < 1) ? 1 : $clog2(MAX_LEN-1),
  localparam int SW = $clog2(STEP_LIMIT+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tbl_we,
  input  logic [AW-1:0] tbl_addr,
  input  logic [W-1:0]  tbl_data,
  input  logic          tbl_valid,
  input  logic          start,
  input  logic [AW-1:0] start_sel,
  input  logic [AW-1:0] sel_word,
  input  logic [LW-1:0] sel_len,
  output logic          busy,
  output logic          found,
  output logic          trapped,
  output logic          timeout,
  output logic [SW-1:0] steps,
  output logic [W-1:0]  word
);

  typedef enum logic [2:0] {
    IDLE, RUN, FOUND, TRAP, TMO
  } state_t;

  state_t         state, state_n;
  logic [W-1:0]   tbl [NUM_WORDS];
  logic [NUM_WORDS-1:0] vld;
  logic           first, first_n;
  logic [W-1:0]   word_n;
  logic [SW-1:0]  steps_n;

  int             n;
  logic           lim_ok, pw_ok, po_ok;
  logic [W-1:0]   mask, other, pw, po;
  logic           hit_t, hit_f, hit_c, hit_d;

  // Code table; writes blocked while a search is running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < NUM_WORDS; i++) tbl[i] <= '0;
    end else if (tbl_we && !busy) begin
      tbl[tbl_addr] <= tbl_data;
      vld[tbl_addr] <= tbl_valid;
    end
  end

  // Prefix views of the open suffix and the chosen table word
  always_comb begin
    n      = (int'(sel_len) + 1) * CHAR_BITS;
    lim_ok = (int'(sel_len) + 1) < MAX_LEN;
    mask   = (W'(1) << n) - W'(1);
    other  = tbl[sel_word];
    pw_ok  = lim_ok && ((word >> (n + 1)) != '0);
    po_ok  = lim_ok && ((other >> (n + 1)) != '0);
    pw     = (word & mask) | (W'(1) << n);
    po     = (other & mask) | (W'(1) << n);
    hit_t  = !vld[sel_word];
    hit_f  = !hit_t && !first && (word == other);
    hit_c  = !hit_t && !hit_f && pw_ok && (other == pw);
    hit_d  = !hit_t && !hit_f && !hit_c && po_ok && (po == word);
  end

  // Next state, next suffix and step accounting
  always_comb begin
    state_n = state;
    word_n  = word;
    steps_n = steps;
    first_n = first;
    if (start) begin
      word_n  = tbl[start_sel];
      steps_n = '0;
      first_n = 1'b1;
      state_n = vld[start_sel] ? RUN : TRAP;
    end else if (state == RUN) begin
      steps_n = steps + 1'b1;
      first_n = 1'b0;
      unique case (1'b1)
        hit_t: state_n = TRAP;
        hit_f: state_n = FOUND;
        hit_c: word_n = word >> n;
        hit_d: word_n = other >> n;
        default: begin
          state_n = TRAP;
          word_n  = '0;
        end
      endcase
      if (state_n == RUN && steps_n == SW'(STEP_LIMIT))
        state_n = TMO;
    end
  end

  // State, datapath and registered status decodes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      word    <= '0;
      steps   <= '0;
      first   <= 1'b0;
      busy    <= 1'b0;
      found   <= 1'b0;
      trapped <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      word    <= word_n;
      steps   <= steps_n;
      first   <= first_n;
      busy    <= state_n == RUN;
      found   <= state_n == FOUND;
      trapped <= state_n == TRAP;
      timeout <= state_n == TMO;
    end
  end

endmodule

// File: tb/tb_unidec_engine.sv
// Randomized bench for unidec_engine against a
// string-level model of the suffix search.
module tb_unidec_engine;

  localparam int CB = 3, ML = 5, NW = 8, SL = 64;
  localparam int W = ML*CB+1, AW = 3, LW = 2, SW = 7;
  localparam int S_IDLE = 0, S_RUN = 1, S_FOUND = 2;
  localparam int S_TRAP = 3, S_TMO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tbl_we = 1'b0;
  logic [AW-1:0] tbl_addr = '0;
  logic [W-1:0]  tbl_data = '0;
  logic          tbl_valid = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_sel = '0;
  logic [AW-1:0] sel_word = '0;
  logic [LW-1:0] sel_len = '0;
  logic          busy, found, trapped, timeout;
  logic [SW-1:0] steps;
  logic [W-1:0]  word;

  unidec_engine dut (
    .clk(clk), .rst_n(rst_n),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data), .tbl_valid(tbl_valid),
    .start(start), .start_sel(start_sel),
    .sel_word(sel_word), .sel_len(sel_len),
    .busy(busy), .found(found), .trapped(trapped),
    .timeout(timeout), .steps(steps), .word(word)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [W-1:0] m_tbl [NW];
  logic         m_vld [NW];
  int           m_st;
  logic [W-1:0] m_word;
  int           m_steps;
  bit           m_first;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic string dec(input logic [W-1:0] x);
    int top = 0;
    int len;
    string s = "";
    for (int b = 0; b < W; b++) if (x[b]) top = b;
    len = top / CB;
    for (int i = 0; i < len; i++) begin
      s = {s, "a"};
      s.putc(i, byte'(97 + int'(x[i*CB +: CB])));
    end
    return s;
  endfunction

  function automatic logic [W-1:0] enc(input string s);
    logic [W-1:0] x = '0;
    for (int i = 0; i < s.len(); i++)
      x = x | (W'(int'(s.getc(i)) - 97) << (i*CB));
    x = x | (W'(1) << (s.len()*CB));
    return x;
  endfunction

  function automatic logic [W-1:0] rnd_word();
    string s = "";
    int len = $urandom_range(1, 3);
    for (int i = 0; i < len; i++) begin
      s = {s, "a"};
      s.putc(i, byte'(97 + $urandom_range(0, 1)));
    end
    return enc(s);
  endfunction

  task automatic model_reset();
    m_st = S_IDLE;
    m_word = '0;
    m_steps = 0;
    m_first = 1'b0;
    for (int i = 0; i < NW; i++) begin
      m_tbl[i] = '0;
      m_vld[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit run_now = (m_st == S_RUN);
    string w, o;
    int k;
    if (start) begin
      m_word = m_tbl[start_sel];
      m_steps = 0;
      m_first = 1'b1;
      m_st = m_vld[start_sel] ? S_RUN : S_TRAP;
    end else if (run_now) begin
      w = dec(m_word);
      o = dec(m_tbl[sel_word]);
      k = int'(sel_len);
      m_steps++;
      if (!m_vld[sel_word])
        m_st = S_TRAP;
      else if (!m_first && w == o)
        m_st = S_FOUND;
      else if (w.len() > k+1 && o == w.substr(0, k))
        m_word = enc(w.substr(k+1, w.len()-1));
      else if (o.len() > k+1 && o.substr(0, k) == w)
        m_word = enc(o.substr(k+1, o.len()-1));
      else begin
        m_st = S_TRAP;
        m_word = '0;
      end
      m_first = 1'b0;
      if (m_st == S_RUN && m_steps == SL) m_st = S_TMO;
    end
    if (tbl_we && !run_now) begin
      m_tbl[tbl_addr] = tbl_data;
      m_vld[tbl_addr] = tbl_valid;
    end
  endtask

  task automatic check_out(input string tag);
    chk({tag, ".flags"},
        {28'd0, busy, found, trapped, timeout},
        {28'd0, m_st == S_RUN, m_st == S_FOUND,
         m_st == S_TRAP, m_st == S_TMO});
    chk({tag, ".steps"}, 32'(steps), 32'(m_steps));
    chk({tag, ".word"}, 32'(word), 32'(m_word));
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    start = 1'b0;
    tbl_we = 1'b0;
    check_out(tag);
  endtask

  task automatic wr(input int a, input logic [W-1:0] d,
                    input logic v);
    tbl_we = 1'b1;
    tbl_addr = AW'(a);
    tbl_data = d;
    tbl_valid = v;
    cyc("wr");
  endtask

  task automatic go(input int s);
    start = 1'b1;
    start_sel = AW'(s);
    cyc("start");
  endtask

  task automatic step(input int w, input int l);
    sel_word = AW'(w);
    sel_len = LW'(l);
    cyc("step");
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_out("rst_async");
    @(posedge clk);
    #1;
    check_out("rst_hold");
    rst_n = 1'b1;
  endtask

  logic [W-1:0] t39 [8] = '{16'h0008, 16'h000A, 16'h0058,
    16'h0248, 16'h02C1, 16'h0263, 16'hC689, 16'h0008};
  int sw39 [6] = '{3, 6, 1, 5, 4, 2};
  int sl39 [6] = '{0, 1, 0, 1, 0, 0};
  logic [W-1:0] ew39 [5] = '{16'h0049, 16'h031A, 16'h0063,
    16'h0009, 16'h0058};

  initial begin
    model_reset();
    do_reset();

    // found path
    for (int i = 0; i < 8; i++) wr(i, t39[i], 1'b1);
    go(0);
    chk("s39_start", 32'(word), 32'h0008);
    for (int i = 0; i < 5; i++) begin
      step(sw39[i], sl39[i]);
      chk("s39_word", 32'(word), 32'(ew39[i]));
    end
    step(sw39[5], sl39[5]);
    chk("s39_found", 32'(found), 32'd1);
    chk("s39_steps", 32'(steps), 32'd6);
    step(3, 0);
    chk("s39_hold", 32'(steps), 32'd6);

    // trap
    go(0);
    step(5, 0);
    chk("trap_flag", 32'(trapped), 32'd1);
    chk("trap_word", 32'(word), 32'd0);
    chk("trap_steps", 32'(steps), 32'd1);

    // first-step suppression
    go(0);
    step(0, 0);
    chk("first_trap", 32'(trapped), 32'd1);
    chk("first_nofound", 32'(found), 32'd0);

    // write lockout during RUN
    go(0);
    tbl_we = 1'b1;
    tbl_addr = '0;
    tbl_data = 16'h1234;
    tbl_valid = 1'b1;
    step(3, 0);
    step(5, 0);
    go(0);
    chk("lock_word", 32'(word), 32'h0008);

    // timeout on an endless a -> b -> a cycle
    wr(0, 16'h0008, 1'b1);
    wr(1, 16'h0048, 1'b1);
    wr(2, 16'h0041, 1'b1);
    wr(3, 16'h0009, 1'b1);
    go(0);
    for (int i = 0; i < SL; i++) step((i % 2 == 0) ? 1 : 2, 0);
    chk("tmo_flag", 32'(timeout), 32'd1);
    chk("tmo_steps", 32'(steps), 32'd64);
    chk("tmo_word", 32'(word), 32'h0008);
    step(1, 0);
    chk("tmo_hold", 32'(steps), 32'd64);

    // reset during the third step of the found path
    for (int i = 0; i < 8; i++) wr(i, t39[i], 1'b1);
    go(0);
    step(3, 0);
    step(6, 1);
    sel_word = AW'(1);
    sel_len = LW'(0);
    do_reset();
    chk("rst_steps", 32'(steps), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    go(0);
    chk("rst_trap", 32'(trapped), 32'd1);

    // write and start together: start sees old entry
    tbl_we = 1'b1;
    tbl_addr = '0;
    tbl_data = 16'h0008;
    tbl_valid = 1'b1;
    go(0);
    chk("ws_old", 32'(trapped), 32'd1);
    go(0);
    chk("ws_new", 32'(busy), 32'd1);

    // randomized episodes
    for (int e = 0; e < 300; e++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      for (int j = 0; j < int'($urandom_range(0, 4)); j++) begin
        if ($urandom_range(0, 7) != 0)
          wr($urandom_range(0, NW-1), rnd_word(), 1'b1);
        else
          wr($urandom_range(0, NW-1), W'($urandom), 1'b0);
      end
      go($urandom_range(0, NW-1));
      for (int j = 0; j < int'($urandom_range(1, 12)); j++) begin
        if ($urandom_range(0, 7) == 0) begin
          tbl_we = 1'b1;
          tbl_addr = AW'($urandom_range(0, NW-1));
          tbl_data = rnd_word();
          tbl_valid = 1'b1;
        end
        if ($urandom_range(0, 15) == 0) begin
          start = 1'b1;
          start_sel = AW'($urandom_range(0, NW-1));
        end
        step($urandom_range(0, NW-1), $urandom_range(0, 3));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
